serial_rx_ctrl: RTL and testbench

Control and buffering block for the asynchronous serial receive path. Generates the 8x-oversampling `baud8tick` strobe from a programmable divisor, captures bytes from the receiver's `rxd_data_ready` strobe into a FIFO, and tracks overrun and inter-packet gaps. Presents a registered pop interface and a level interrupt to the host/bus-slave wrapper; sits between the bus slave and the receiver core.

---
 rtl/serial_rx_ctrl_if.sv | 32 +++
 rtl/serial_rx_ctrl.sv | 144 ++++++++++++++
 tb/tb_serial_rx_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_ctrl_if.sv
// Host-side bus bundle for serial_rx_ctrl: divisor load, interrupt setup,
// FIFO pop port and status flags.
interface serial_rx_ctrl_if #(
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 16
);
    logic               div_we;
    logic [DIV_W-1:0]   div_in;
    logic [FIFO_AW:0]   thr;
    logic               ovr_ie;
    logic               flush;
    logic               rd_en;
    logic               ovr_clr;
    logic [7:0]         rd_data;
    logic               rd_valid;
    logic [FIFO_AW:0]   count;
    logic               empty;
    logic               full;
    logic               overrun;
    logic               timeout;
    logic               irq;

    modport master (
        output div_we, div_in, thr, ovr_ie, flush, rd_en, ovr_clr,
        input  rd_data, rd_valid, count, empty, full, overrun, timeout, irq
    );

    modport slave (
        input  div_we, div_in, thr, ovr_ie, flush, rd_en, ovr_clr,
        output rd_data, rd_valid, count, empty, full, overrun, timeout, irq
    );
endinterface

// File: rtl/serial_rx_ctrl.sv
// Serial receive control: 8x baud tick generator, receive byte FIFO with
// overrun/timeout tracking and level interrupt. Optional macro: SERIAL_RX_TIMEOUT_EN.
module serial_rx_ctrl #(
    parameter int               FIFO_AW   = 4,
    parameter int               DIV_W     = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(27)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  baud8tick,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_ready,
    input  logic                  rx_endofpacket,
    serial_rx_ctrl_if.slave       bus
);
    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);

    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   div;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_nxt;
    logic               empty_w;
    logic               full_w;
    logic               pop_acc;
    logic               push_acc;
    logic               ovr_evt;
    logic               overrun_q;
    logic               timeout_q;

    // A divisor load restarts the countdown and suppresses the tick in that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= DIV_RESET;
            div       <= DIV_RESET;
            baud8tick <= 1'b0;
        end else if (bus.div_we) begin
            cnt       <= bus.div_in;
            div       <= bus.div_in;
            baud8tick <= 1'b0;
        end else if (cnt == '0) begin
            cnt       <= div;
            baud8tick <= 1'b1;
        end else begin
            cnt       <= cnt - 1'b1;
            baud8tick <= 1'b0;
        end
    end

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == DEPTH_C);
    // A pop frees a slot in the same cycle, so push onto a full FIFO still succeeds
    assign pop_acc  = bus.rd_en && !empty_w && !bus.flush;
    assign push_acc = rx_data_ready && !bus.flush && (!full_w || pop_acc);
    assign ovr_evt  = rx_data_ready && !bus.flush && full_w && !pop_acc;

    always_comb begin
        count_nxt = count_q;
        if (bus.flush) begin
            count_nxt = '0;
        end else if (push_acc && !pop_acc) begin
            count_nxt = count_q + 1'b1;
        end else if (pop_acc && !push_acc) begin
            count_nxt = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count_q      <= '0;
            bus.rd_data  <= 8'h00;
            bus.rd_valid <= 1'b0;
        end else begin
            count_q      <= count_nxt;
            bus.rd_valid <= pop_acc;
            if (bus.flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push_acc) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop_acc) begin
                    rptr        <= rptr + 1'b1;
                    bus.rd_data <= mem[rptr];
                end
            end
        end
    end

    // A fresh overrun event outranks a clear requested in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (ovr_evt) begin
            overrun_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef SERIAL_RX_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (bus.flush || pop_acc || (count_nxt == '0)) begin
            timeout_q <= 1'b0;
        end else if (rx_endofpacket && !empty_w) begin
            timeout_q <= 1'b1;
        end
    end
`else
    logic unused_eop;
    assign unused_eop = rx_endofpacket;
    assign timeout_q  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.irq <= 1'b0;
        end else begin
            bus.irq <= ((bus.thr != '0) && (count_q >= bus.thr))
                     | timeout_q
                     | (overrun_q & bus.ovr_ie);
        end
    end

    assign bus.count   = count_q;
    assign bus.empty   = empty_w;
    assign bus.full    = full_w;
    assign bus.overrun = overrun_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Bench for serial_rx_ctrl: queue-based reference model checked every cycle,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_serial_rx_ctrl;
    localparam int FIFO_AW = 4;
    localparam int DIV_W   = 16;
    localparam int DEPTH   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud8tick;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_endofpacket;

    serial_rx_ctrl_if #(.FIFO_AW(FIFO_AW), .DIV_W(DIV_W)) bus ();

    serial_rx_ctrl #(.FIFO_AW(FIFO_AW), .DIV_W(DIV_W), .DIV_RESET(16'd27)) dut (
        .clk            (clk),
        .rst            (rst),
        .baud8tick      (baud8tick),
        .rx_data        (rx_data),
        .rx_data_ready  (rx_data_ready),
        .rx_endofpacket (rx_endofpacket),
        .bus            (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Reference state: FIFO as a queue, tick as edges elapsed since last anchor
    byte unsigned q[$];
    logic [7:0]   m_rd_data  = 8'h00;
    bit           m_rd_valid = 1'b0;
    bit           m_ovr      = 1'b0;
    bit           m_to       = 1'b0;
    bit           m_irq      = 1'b0;
    bit           m_tick     = 1'b0;
    int           m_edges    = 0;
    int           m_period   = 28;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        int old_size;
        bit pop_ok;
        bit ovr_evt;
        if (rst) begin
            q.delete();
            m_rd_data  = 8'h00;
            m_rd_valid = 1'b0;
            m_ovr      = 1'b0;
            m_to       = 1'b0;
            m_irq      = 1'b0;
            m_tick     = 1'b0;
            m_edges    = 0;
            m_period   = 28;
        end else begin
            old_size = q.size();
            m_irq = ((bus.thr != 0) && (old_size >= int'(bus.thr))) || m_to || (m_ovr && bus.ovr_ie);
            if (bus.div_we) begin
                m_edges  = 0;
                m_period = int'(bus.div_in) + 1;
                m_tick   = 1'b0;
            end else begin
                m_edges++;
                m_tick = ((m_edges % m_period) == 0);
            end
            pop_ok = bus.rd_en && (old_size > 0) && !bus.flush;
            if (bus.flush) begin
                q.delete();
                m_rd_valid = 1'b0;
                m_to       = 1'b0;
                if (bus.ovr_clr) m_ovr = 1'b0;
            end else begin
                if (pop_ok) m_rd_data = q.pop_front();
                m_rd_valid = pop_ok;
                ovr_evt = 1'b0;
                if (rx_data_ready) begin
                    if (q.size() < DEPTH) q.push_back(rx_data);
                    else ovr_evt = 1'b1;
                end
                if (ovr_evt) m_ovr = 1'b1;
                else if (bus.ovr_clr) m_ovr = 1'b0;
`ifdef SERIAL_RX_TIMEOUT_EN
                if (pop_ok || q.size() == 0) m_to = 1'b0;
                else if (rx_endofpacket && old_size > 0) m_to = 1'b1;
`endif
            end
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            check_output("baud8tick", baud8tick, m_tick);
            check_output("rd_valid", bus.rd_valid, m_rd_valid);
            check_output("rd_data", bus.rd_data, m_rd_data);
            check_output("count", bus.count, q.size());
            check_output("empty", bus.empty, q.size() == 0);
            check_output("full", bus.full, q.size() == DEPTH);
            check_output("overrun", bus.overrun, m_ovr);
            check_output("timeout", bus.timeout, m_to);
            check_output("irq", bus.irq, m_irq);
        end
    end

    // One-cycle pulse of the per-cycle strobes, entered and left on a falling edge
    task automatic apply_stimulus(input bit push, input logic [7:0] data, input bit pop,
                                  input bit eop, input bit fl, input bit oclr);
        rx_data_ready  = push;
        rx_data        = data;
        bus.rd_en      = pop;
        rx_endofpacket = eop;
        bus.flush      = fl;
        bus.ovr_clr    = oclr;
        @(negedge clk);
        rx_data_ready  = 1'b0;
        bus.rd_en      = 1'b0;
        rx_endofpacket = 1'b0;
        bus.flush      = 1'b0;
        bus.ovr_clr    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_baud8tick"}, baud8tick, 1'b0);
        check_output({tag, "_rd_data"}, bus.rd_data, 8'h00);
        check_output({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
        check_output({tag, "_count"}, bus.count, 0);
        check_output({tag, "_empty"}, bus.empty, 1'b1);
        check_output({tag, "_full"}, bus.full, 1'b0);
        check_output({tag, "_overrun"}, bus.overrun, 1'b0);
        check_output({tag, "_timeout"}, bus.timeout, 1'b0);
        check_output({tag, "_irq"}, bus.irq, 1'b0);
    endtask

    initial begin
        int ticks;
        int first_tick;
        rst = 1'b1;
        rx_data = 8'h00; rx_data_ready = 1'b0; rx_endofpacket = 1'b0;
        bus.div_we = 1'b0; bus.div_in = '0; bus.thr = '0; bus.ovr_ie = 1'b0;
        bus.flush = 1'b0; bus.rd_en = 1'b0; bus.ovr_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        cmp_en = 1'b1;

        ticks = 0; first_tick = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (baud8tick) begin
                ticks++;
                if (first_tick == 0) first_tick = i;
            end
        end
        check_output("first_tick_clock", first_tick, 28);
        check_output("ticks_in_60", ticks, 2);

        bus.div_we = 1'b1; bus.div_in = 16'd3;
        @(negedge clk);
        bus.div_we = 1'b0;
        check_output("tick_in_load_cycle", baud8tick, 1'b0);
        ticks = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (baud8tick) ticks++;
        end
        check_output("ticks_div3_in_12", ticks, 3);

        apply_stimulus(1, 8'h41, 0, 0, 0, 0);
        apply_stimulus(1, 8'h42, 0, 0, 0, 0);
        apply_stimulus(1, 8'h43, 0, 0, 0, 0);
        apply_stimulus(0, 8'h00, 1, 0, 0, 0);
        check_output("pop0_data", bus.rd_data, 8'h41);
        apply_stimulus(0, 8'h00, 1, 0, 0, 0);
        check_output("pop1_data", bus.rd_data, 8'h42);
        apply_stimulus(0, 8'h00, 1, 0, 0, 0);
        check_output("pop2_data", bus.rd_data, 8'h43);
        check_output("pop2_valid", bus.rd_valid, 1'b1);
        check_output("empty_after_pops", bus.empty, 1'b1);
        apply_stimulus(0, 8'h00, 1, 0, 0, 0);
        check_output("pop_empty_valid", bus.rd_valid, 1'b0);
        check_output("pop_empty_hold", bus.rd_data, 8'h43);

        for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 8'(8'h10 + i), 0, 0, 0, 0);
        check_output("fill_count", bus.count, 16);
        check_output("fill_full", bus.full, 1'b1);
        apply_stimulus(1, 8'h99, 0, 0, 0, 0);
        check_output("ovr_set", bus.overrun, 1'b1);
        check_output("ovr_count", bus.count, 16);
        bus.ovr_ie = 1'b1;
        apply_stimulus(0, 8'h00, 0, 0, 0, 0);
        check_output("ovr_irq", bus.irq, 1'b1);
        apply_stimulus(0, 8'h00, 0, 0, 0, 1);
        check_output("ovr_clr", bus.overrun, 1'b0);
        apply_stimulus(1, 8'hAA, 1, 0, 0, 0);
        check_output("full_pushpop_data", bus.rd_data, 8'h10);
        check_output("full_pushpop_count", bus.count, 16);
        check_output("full_pushpop_ovr", bus.overrun, 1'b0);
        bus.ovr_ie = 1'b0;
        for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 8'h00, 1, 0, 0, 0);
        check_output("drain_last", bus.rd_data, 8'hAA);
        check_output("drain_empty", bus.empty, 1'b1);

        bus.thr = 5'd4;
        for (int i = 0; i < 3; i++) apply_stimulus(1, 8'(8'h51 + i), 0, 0, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0, 0, 0);
        check_output("thr_below_irq", bus.irq, 1'b0);
        apply_stimulus(1, 8'h54, 0, 0, 0, 0);
        check_output("thr_count4", bus.count, 4);
        check_output("thr_irq_lag", bus.irq, 1'b0);
        apply_stimulus(0, 8'h00, 0, 0, 0, 0);
        check_output("thr_irq_set", bus.irq, 1'b1);
        apply_stimulus(0, 8'h00, 1, 0, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0, 0, 0);
        check_output("thr_irq_drop", bus.irq, 1'b0);
        bus.thr = '0;
        for (int i = 0; i < 3; i++) apply_stimulus(0, 8'h00, 1, 0, 0, 0);

        apply_stimulus(1, 8'h77, 0, 0, 0, 0);
        apply_stimulus(0, 8'h00, 0, 1, 0, 0);
`ifdef SERIAL_RX_TIMEOUT_EN
        check_output("to_set", bus.timeout, 1'b1);
        apply_stimulus(0, 8'h00, 0, 0, 0, 0);
        check_output("to_irq", bus.irq, 1'b1);
        apply_stimulus(0, 8'h00, 1, 0, 0, 0);
        check_output("to_pop_clr", bus.timeout, 1'b0);
        apply_stimulus(0, 8'h00, 0, 0, 0, 0);
        check_output("to_irq_clr", bus.irq, 1'b0);
`else
        check_output("to_disabled", bus.timeout, 1'b0);
        apply_stimulus(0, 8'h00, 0, 0, 0, 0);
        check_output("to_disabled_irq", bus.irq, 1'b0);
        apply_stimulus(0, 8'h00, 1, 0, 0, 0);
`endif
        apply_stimulus(0, 8'h00, 0, 1, 0, 0);
        check_output("to_empty_eop", bus.timeout, 1'b0);

        for (int i = 0; i < DEPTH + 1; i++) apply_stimulus(1, 8'(8'h20 + i), 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) apply_stimulus(0, 8'h00, 1, 0, 0, 0);
        check_output("pre_flush_count", bus.count, 5);
        apply_stimulus(1, 8'hEE, 0, 0, 1, 0);
        check_output("flush_count", bus.count, 0);
        check_output("flush_empty", bus.empty, 1'b1);
        check_output("flush_ovr_kept", bus.overrun, 1'b1);
        check_output("flush_rd_valid", bus.rd_valid, 1'b0);
        apply_stimulus(0, 8'h00, 0, 0, 0, 1);

        // Alternate push-heavy and pop-heavy windows so full and empty both occur
        for (int c = 0; c < 2000; c++) begin
            int push_pct;
            push_pct = ((c / 200) % 2 == 0) ? 75 : 30;
            if (c % 100 == 0) bus.thr = 5'($urandom_range(0, 16));
            if (c % 37 == 0) bus.ovr_ie = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                bus.div_we = 1'b1;
                bus.div_in = 16'($urandom_range(0, 5));
            end
            apply_stimulus(($urandom_range(0, 99) < push_pct), 8'($urandom),
                           ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 8),
                           ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5));
            bus.div_we = 1'b0;
        end

        for (int i = 0; i < 6; i++) apply_stimulus(1, 8'(8'hC0 + i), 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (40) apply_stimulus(0, 8'h00, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
